// File: rtl/ascon_pack.sv
// Shared ASCON definitions: 320-bit state type, the 5-bit S-box table,
// the substitution-layer FSM encoding and a column gather helper.
package ascon_pack;

    // x0 is word 0, x4 is word 4; bit j of every word forms column j.
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sbox_layer_fsm_t;

    localparam logic [4:0] sub_constant [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // Column j as a 5-bit value with x0 in the MSB.
    function automatic logic [4:0] get_column(input type_state s, input logic [5:0] j);
        return {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
    endfunction

endpackage

// File: rtl/sbox.sv
// Single 5-bit ASCON S-box lookup.
module sbox
    import ascon_pack::*;
(
    input  logic [4:0] S_i,
    output logic [4:0] S_o
);

    always_comb begin
        S_o = sub_constant[S_i];
    end

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative ASCON substitution layer: NB_LANES S-box columns per cycle over
// the 320-bit state, with valid/ready handshakes on input and output.
module sbox_layer_iter
    import ascon_pack::*;
#(
    parameter int NB_LANES = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state state_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state state_o
);

    localparam int NB_STEPS = 64 / NB_LANES;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_STEPS - 1);

    generate
        if (!(NB_LANES == 1  || NB_LANES == 2  || NB_LANES == 4 || NB_LANES == 8 ||
              NB_LANES == 16 || NB_LANES == 32 || NB_LANES == 64)) begin : g_bad_lanes
            $error("sbox_layer_iter: NB_LANES must be a power of two from 1 to 64");
        end
    endgenerate

    sbox_layer_fsm_t  fsm_q;
    logic [CNT_W-1:0] cnt_q;
    type_state        work_q;
    logic             ready_q;
    logic             valid_q;

    logic [5:0] base_idx;
    logic [5:0] lane_idx [NB_LANES];
    logic [4:0] col_in   [NB_LANES];
    logic [4:0] col_out  [NB_LANES];

    // Lane mux: each lane reads its column of the current step straight from work_q.
    always_comb begin
        base_idx = 6'(32'(cnt_q) * NB_LANES);
        for (int l = 0; l < NB_LANES; l++) begin
            lane_idx[l] = base_idx + 6'(l);
            col_in[l]   = get_column(work_q, lane_idx[l]);
        end
    end

    for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
        sbox u_sbox (
            .S_i (col_in[gi]),
            .S_o (col_out[gi])
        );
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    // Coming out of reset ready_q is still low, so the first
                    // cycle only raises ready and cannot accept.
                    ready_q <= 1'b1;
                    if (ready_q && valid_i) begin
                        work_q  <= state_i;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < NB_LANES; l++) begin
                        for (int k = 0; k < 5; k++) begin
                            work_q[k][lane_idx[l]] <= col_out[l][4-k];
                        end
                    end
                    if (cnt_q == LAST_STEP) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        fsm_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        fsm_q   <= IDLE;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ready_o = ready_q;
        valid_o = valid_q;
        state_o = work_q;
    end

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Self-checking bench for sbox_layer_iter at NB_LANES = 8, 1 and 64 against a
// column-by-column table model of the ASCON substitution layer.
`timescale 1ns/1ps
module tb_sbox_layer_iter;
    import ascon_pack::*;

    localparam int NI = 3;

    function automatic int lanes_of(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 64;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic      rst;
    logic      v_in   [NI];
    logic      r_in   [NI];
    type_state st_in  [NI];
    logic      v_out  [NI];
    logic      r_out  [NI];
    type_state st_out [NI];

    int errors = 0;
    int checks = 0;

    int sbox_tab [32] = '{
        'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
        'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
        'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
        'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
    };

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sbox_layer_iter #(.NB_LANES(lanes_of(gi))) u_dut (
            .clock_i (clk),
            .reset_i (rst),
            .valid_i (v_in[gi]),
            .ready_o (r_out[gi]),
            .state_i (st_in[gi]),
            .valid_o (v_out[gi]),
            .ready_i (r_in[gi]),
            .state_o (st_out[gi])
        );
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: substitute every column independently through the table.
    function automatic type_state ref_sub(input type_state s);
        type_state r;
        int col;
        int outv;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            col = 0;
            for (int k = 0; k < 5; k++) col = col * 2 + int'(s[k][j]);
            outv = sbox_tab[col];
            for (int k = 0; k < 5; k++) r[k][j] = 1'((outv >> (4 - k)) & 1);
        end
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic type_state walk_state();
        type_state s;
        for (int j = 0; j < 64; j++)
            for (int k = 0; k < 5; k++) s[k][j] = 1'(((j % 32) >> (4 - k)) & 1);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int k, input type_state s, input type_state exp,
                           input int hold, input string tag);
        int n;
        n = 0;
        while (!r_out[k] && n < 300) begin tick(); n++; end
        check({tag, "_rdy"}, 320'(r_out[k]), 320'(1));
        st_in[k] = s;
        v_in[k]  = 1'b1;
        r_in[k]  = 1'b0;
        tick();
        v_in[k]  = 1'b0;
        st_in[k] = rand_state();
        check({tag, "_busy"}, 320'(r_out[k]), 320'(0));
        n = 0;
        while (!v_out[k] && n < 300) begin tick(); n++; end
        check({tag, "_lat"}, 320'(n), 320'(64 / lanes_of(k)));
        check({tag, "_data"}, st_out[k], exp);
        for (int c = 0; c < hold; c++) begin
            v_in[k]  = 1'(c & 1);
            st_in[k] = rand_state();
            tick();
            check({tag, "_hold_v"}, 320'(v_out[k]), 320'(1));
            check({tag, "_hold_d"}, st_out[k], exp);
            check({tag, "_hold_r"}, 320'(r_out[k]), 320'(0));
        end
        v_in[k] = 1'b0;
        r_in[k] = 1'b1;
        tick();
        r_in[k] = 1'b0;
        check({tag, "_rel_v"}, 320'(v_out[k]), 320'(0));
        check({tag, "_rel_r"}, 320'(r_out[k]), 320'(1));
        tick();
        check({tag, "_idle_r"}, 320'(r_out[k]), 320'(1));
        $display("txn %s dut%0d lanes=%0d latency=%0d", tag, k, lanes_of(k), n);
    endtask

    type_state e_zero, e_ones, zero_s, ones_s, s;
    type_state stream [4];
    type_state exp_q [$];
    int idx, nout, last, cyc;
    logic acc;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            v_in[k] = 1'b0; r_in[k] = 1'b0; st_in[k] = '0;
        end
        zero_s = '0;
        ones_s = '1;
        e_zero = '0;
        e_zero[2] = '1;
        e_ones = '1;
        e_ones[1] = '0;

        tick(); tick(); tick();
        for (int k = 0; k < NI; k++) begin
            check("rst_ready", 320'(r_out[k]), 320'(0));
            check("rst_valid", 320'(v_out[k]), 320'(0));
            check("rst_state", st_out[k], '0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < NI; k++) check("rel_ready", 320'(r_out[k]), 320'(1));

        run_txn(0, zero_s, e_zero, 0, "zero8");
        run_txn(0, ones_s, e_ones, 0, "ones8");
        run_txn(1, ones_s, e_ones, 0, "ones1");
        run_txn(2, ones_s, e_ones, 0, "ones64");
        run_txn(1, zero_s, e_zero, 0, "zero1");
        run_txn(2, zero_s, e_zero, 0, "zero64");
        for (int k = 0; k < NI; k++) run_txn(k, walk_state(), ref_sub(walk_state()), 0, "walk");

        s = rand_state();
        run_txn(0, s, ref_sub(s), 10, "bp");

        // Reset in the middle of RUN, three steps in.
        while (!r_out[0]) tick();
        st_in[0] = rand_state();
        v_in[0]  = 1'b1;
        tick();
        v_in[0] = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", 320'(r_out[0]), 320'(0));
        check("midrst_valid", 320'(v_out[0]), 320'(0));
        check("midrst_state", st_out[0], '0);
        rst = 1'b0;
        tick();
        check("postrst_ready", 320'(r_out[0]), 320'(1));
        check("postrst_valid", 320'(v_out[0]), 320'(0));
        check("postrst_state", st_out[0], '0);
        $display("txn midrst dut0 ready=%0d valid=%0d", r_out[0], v_out[0]);
        s = rand_state();
        run_txn(0, s, ref_sub(s), 2, "postrst");

        // Streaming with ready_i tied high and valid_i held.
        for (int i = 0; i < 4; i++) stream[i] = rand_state();
        exp_q.delete();
        idx = 0; nout = 0; last = -1; cyc = 0;
        r_in[0] = 1'b1; st_in[0] = stream[0]; v_in[0] = 1'b1;
        while (nout < 4 && cyc < 300) begin
            acc = r_out[0] && v_in[0];
            if (v_out[0]) begin
                if (exp_q.size() == 0) check("stream_extra", 320'(1), 320'(0));
                else check("stream_data", st_out[0], exp_q.pop_front());
                if (last >= 0) check("stream_gap", 320'(cyc - last), 320'(64 / lanes_of(0) + 2));
                $display("txn stream out%0d at cycle %0d", nout, cyc);
                last = cyc;
                nout++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (idx < 4) exp_q.push_back(ref_sub(stream[idx]));
                idx++;
                if (idx < 4) st_in[0] = stream[idx];
                else v_in[0] = 1'b0;
            end
        end
        check("stream_count", 320'(nout), 320'(4));
        r_in[0] = 1'b0;
        v_in[0] = 1'b0;
        tick();

        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NI; k++) begin
                s = rand_state();
                run_txn(k, s, ref_sub(s), r, "rand");
            end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
